// File: rtl/serial_word_tx.sv
// serial_word_tx -- queues multi-byte words in a small FIFO and sends them
// byte by byte through a UART transmitter.
//
// Optional feature: define SERIAL_TX_CHECKSUM_EN to append an XOR checksum
// byte after the BYTES data bytes of every word.
//
// Ports (serial_word_tx):
//   clk    : the only clock
//   reset  : asynchronous, active-high
//   word   : data word, 8*BYTES bits
//   send   : write strobe, one word per cycle, ignored while full
//   full   : FIFO holds FIFO_DEPTH words
//   busy   : FIFO non-empty or serialiser active
//   level  : number of queued words
//   TxD    : serial line (8N1, idle high)
//
// uart_transmitter (same file) is the 8N1 line driver. It has no reset;
// its all-zero register state is the idle line.

module uart_transmitter #(
  parameter int baud_rate          = 115_200,
  parameter int comm_clk_frequency = 100_000_000
) (
  input  logic       clk,
  input  logic       rx_new_byte,
  input  logic [7:0] rx_byte,
  output logic       tx_ready,
  output logic       uart_tx
);
  localparam int DIV_RAW = comm_clk_frequency / baud_rate;
  localparam int DIV     = (DIV_RAW > 1) ? DIV_RAW : 1;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] baud_cnt;
  logic [3:0]    bits_left;   // 0 = idle, otherwise frame bits still to send
  logic [9:0]    frame;       // {stop, data[7:0], start}, shifted out LSB first

  // A byte in flight always completes, so there is deliberately no reset.
  always_ff @(posedge clk) begin
    if (bits_left == 4'd0) begin
      if (rx_new_byte) begin
        frame     <= {1'b1, rx_byte, 1'b0};
        bits_left <= 4'd10;
        baud_cnt  <= '0;
      end
    end else if (baud_cnt == DW'(DIV - 1)) begin
      baud_cnt  <= '0;
      frame     <= {1'b1, frame[9:1]};
      bits_left <= bits_left - 4'd1;
    end else begin
      baud_cnt  <= baud_cnt + 1'b1;
    end
  end

  assign tx_ready = (bits_left == 4'd0);
  assign uart_tx  = tx_ready ? 1'b1 : frame[0];
endmodule

module serial_word_tx #(
  parameter int baud_rate          = 115_200,
  parameter int comm_clk_frequency = 100_000_000,
  parameter int BYTES              = 4,
  parameter int FIFO_DEPTH         = 4,
  parameter int MSB_FIRST          = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [8*BYTES-1:0]            word,
  input  logic                          send,
  output logic                          full,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          TxD
);
  localparam int W  = 8 * BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BYTES + 2);   // room for the checksum count too
  localparam logic [CW-1:0] BYTES_C = CW'(BYTES);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, HOLD
`ifdef SERIAL_TX_CHECKSUM_EN
    , CHK
`endif
  } state_t;

  state_t          state;
  logic [W-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level_q;
  logic [W-1:0]    sr;
  logic [CW-1:0]   cnt;
  logic [7:0]      out_byte;
  logic            start;
  logic            hold_first;   // first HOLD cycle: uart has not latched yet
  logic            tx_ready;
  logic            push, pop, empty;
  logic [7:0]      next_byte;
  logic [W-1:0]    next_sr;
`ifdef SERIAL_TX_CHECKSUM_EN
  logic [7:0]      acc;
`endif

  // full is taken from the registered level, so a push in a pop cycle
  // while full is still rejected.
  assign full  = (level_q == LW'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  assign push  = send & ~full;
  assign pop   = (state == LOAD);
  assign level = level_q;
  assign busy  = ~empty | (state != IDLE);

  assign next_byte = (MSB_FIRST != 0) ? sr[W-1 -: 8] : sr[7:0];
  assign next_sr   = (MSB_FIRST != 0) ? (sr << 8) : (sr >> 8);

  // NOTE: word storage has no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  // NOTE: every clocked block uses non-blocking assignments so all
  // registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;   // power-of-two depth wraps naturally
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      start      <= 1'b0;
      out_byte   <= '0;
      sr         <= '0;
      cnt        <= '0;
      hold_first <= 1'b0;
`ifdef SERIAL_TX_CHECKSUM_EN
      acc        <= '0;
`endif
    end else begin
      start <= 1'b0;   // start is a single-cycle pulse unless set below
      case (state)
        IDLE: if (!empty) state <= LOAD;
        LOAD: begin
          sr    <= mem[rd_ptr];
          cnt   <= '0;
`ifdef SERIAL_TX_CHECKSUM_EN
          acc   <= '0;
`endif
          state <= START;
        end
        START: if (tx_ready) begin
          start      <= 1'b1;
          out_byte   <= next_byte;
          sr         <= next_sr;
          cnt        <= cnt + 1'b1;
`ifdef SERIAL_TX_CHECKSUM_EN
          acc        <= acc ^ next_byte;
`endif
          hold_first <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          // tx_ready is still high while start is on the wire; ignore it
          // for one cycle so the uart has latched the byte.
          if (hold_first) begin
            hold_first <= 1'b0;
          end else if (tx_ready) begin
            if (cnt < BYTES_C)      state <= START;
`ifdef SERIAL_TX_CHECKSUM_EN
            else if (cnt == BYTES_C) state <= CHK;
`endif
            else if (!empty)        state <= LOAD;
            else                    state <= IDLE;
          end
        end
`ifdef SERIAL_TX_CHECKSUM_EN
        CHK: if (tx_ready) begin
          start      <= 1'b1;
          out_byte   <= acc;
          cnt        <= cnt + 1'b1;
          hold_first <= 1'b1;
          state      <= HOLD;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  uart_transmitter #(
    .baud_rate          (baud_rate),
    .comm_clk_frequency (comm_clk_frequency)
  ) u_uart (
    .clk         (clk),
    .rx_new_byte (start),
    .rx_byte     (out_byte),
    .tx_ready    (tx_ready),
    .uart_tx     (TxD)
  );
endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx -- directed plus randomised checks of serial_word_tx.
// Two instances: dut (MSB first) and dut2 (LSB first). A line decoder turns
// each TxD back into bytes; a word-level model predicts the byte stream.
module tb_serial_word_tx;
  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = CLK_HZ / 16;
  localparam int BIT    = 16;
  localparam int DEPTH  = 4;
`ifdef SERIAL_TX_CHECKSUM_EN
  localparam int BPW = 5;
`else
  localparam int BPW = 4;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] word, word2;
  logic        send, send2;
  logic        full, busy, full2, busy2;
  logic [2:0]  level, level2;
  logic        txd, txd2;
  logic [1:0]  lines;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_log[$];
  logic prev_start = 1'b0;
  logic [7:0] rx_q0[$], rx_q1[$], exp0[$], exp1[$];
  logic [31:0] m_words[$];

  always #5 clk = ~clk;
  assign lines = {txd2, txd};

  serial_word_tx #(.baud_rate(BAUD), .comm_clk_frequency(CLK_HZ), .BYTES(4),
                   .FIFO_DEPTH(DEPTH), .MSB_FIRST(1)) dut (
    .clk(clk), .reset(reset), .word(word), .send(send), .full(full),
    .busy(busy), .level(level), .TxD(txd));

  serial_word_tx #(.baud_rate(BAUD), .comm_clk_frequency(CLK_HZ), .BYTES(4),
                   .FIFO_DEPTH(DEPTH), .MSB_FIRST(0)) dut2 (
    .clk(clk), .reset(reset), .word(word2), .send(send2), .full(full2),
    .busy(busy2), .level(level2), .TxD(txd2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line bytes of one word, MSB first, plus optional XOR byte.
  function automatic void add_word_msb(input logic [31:0] w);
    logic [7:0] x = 8'h00;
    for (int i = 3; i >= 0; i--) begin
      exp0.push_back(8'((w >> (8 * i)) & 32'hFF));
      x ^= 8'((w >> (8 * i)) & 32'hFF);
    end
`ifdef SERIAL_TX_CHECKSUM_EN
    exp0.push_back(x);
`endif
  endfunction

  function automatic void add_word_lsb(input logic [31:0] w);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 4; i++) begin
      exp1.push_back(8'((w >> (8 * i)) & 32'hFF));
      x ^= 8'((w >> (8 * i)) & 32'hFF);
    end
`ifdef SERIAL_TX_CHECKSUM_EN
    exp1.push_back(x);
`endif
  endfunction

  // Word-level model: accept while fewer than DEPTH words are waiting
  // (judged before the pop in the same cycle); words leave when dut pops.
  always @(posedge clk) begin
    if (reset) begin
      m_words.delete();
      exp0.delete();
    end else begin
      if (send && m_words.size() < DEPTH) begin
        m_words.push_back(word);
        add_word_msb(word);
      end
      if (dut.pop && m_words.size() > 0) void'(m_words.pop_front());
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Start-pulse rules: never while the uart is busy, never two in a row.
  always @(negedge clk) begin
    if (dut.start) begin
      check("start_while_ready", dut.tx_ready, 1'b1);
      check("start_not_back_to_back", prev_start, 1'b0);
      start_log.push_back(cyc);
    end
    prev_start <= dut.start;
  end

  task automatic rx_loop(input int idx);
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (lines[idx] == 1'b0) begin
        repeat (BIT / 2 - 1) @(negedge clk);
        check($sformatf("rx%0d_start_bit", idx), lines[idx], 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = lines[idx];
        end
        repeat (BIT) @(negedge clk);
        check($sformatf("rx%0d_stop_bit", idx), lines[idx], 1'b1);
        if (idx == 0) rx_q0.push_back(b);
        else          rx_q1.push_back(b);
      end
    end
  endtask

  initial rx_loop(0);
  initial rx_loop(1);

  task automatic wait_idle(input string tag, input int which, input int budget);
    int n = 0;
    while (((which == 0) ? busy : busy2) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, (which == 0) ? busy : busy2, 1'b0);
  endtask

  task automatic compare_stream(input string tag, input int which);
    int n;
    if (which == 0) begin
      check({tag, "_byte_count"}, rx_q0.size(), exp0.size());
      n = (rx_q0.size() < exp0.size()) ? rx_q0.size() : exp0.size();
      for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), rx_q0[i], exp0[i]);
      rx_q0.delete();
      exp0.delete();
    end else begin
      check({tag, "_byte_count"}, rx_q1.size(), exp1.size());
      n = (rx_q1.size() < exp1.size()) ? rx_q1.size() : exp1.size();
      for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), rx_q1[i], exp1[i]);
      rx_q1.delete();
      exp1.delete();
    end
  endtask

  initial begin
    #(10 * 80_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, c0, lat, n;
    logic [31:0] rnd;
    reset = 1'b1; send = 1'b0; send2 = 1'b0; word = '0; word2 = '0;
    repeat (3) @(negedge clk);
    check("rst_level", level, 3'd0);
    check("rst_full", full, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_start", dut.start, 1'b0);
    check("rst_txd", txd, 1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single word, both byte orders.
    base = start_log.size();
    c0 = cyc;
    word = 32'hDEADBEEF; send = 1'b1;
    word2 = 32'h01020304; send2 = 1'b1;
    add_word_lsb(32'h01020304);
    @(negedge clk);
    send = 1'b0; send2 = 1'b0;
    wait_idle("single", 0, 2000);
    check("single_tx_ready_at_idle", dut.tx_ready, 1'b1);
    check("single_start_pulses", start_log.size() - base, BPW);
    lat = (start_log.size() > base) ? start_log[base] - (c0 + 1) : 0;
    check("single_first_start_latency", lat >= 2, 1'b1);
    compare_stream("single_msb", 0);
    wait_idle("lsb", 1, 500);
    compare_stream("single_lsb", 1);

    rnd = $urandom;
    word2 = rnd; send2 = 1'b1;
    add_word_lsb(rnd);
    @(negedge clk);
    send2 = 1'b0;
    wait_idle("lsb_rand", 1, 2000);
    compare_stream("lsb_rand", 1);

    // FIFO fill while the serialiser is busy with another word.
    base = start_log.size();
    word = 32'hCAFEF00D; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    n = 0;
    while (start_log.size() <= base && n < 100) begin @(negedge clk); n++; end
    check("fill_first_pop_timeout", start_log.size() > base, 1'b1);
    check("fill_start_level", level, 3'd0);
    for (int i = 0; i < 6; i++) begin
      word = 32'h11111111 * (i + 1); send = 1'b1;
      @(negedge clk);
      check($sformatf("fill_level_%0d", i), level, (i < 4) ? i + 1 : 4);
      check($sformatf("fill_full_%0d", i), full, i >= 3);
    end
    send = 1'b0;

    // Push attempted in the very cycle the FSM pops from a full FIFO.
    n = 0;
    while (!dut.pop && n < 3000) begin @(negedge clk); n++; end
    check("pp_pop_timeout", dut.pop, 1'b1);
    check("pp_full_before", full, 1'b1);
    word = 32'h77777777; send = 1'b1;
    @(negedge clk);
    check("pp_rejected_level", level, 3'd3);
    check("pp_not_full", full, 1'b0);
    word = 32'h88888888;
    @(negedge clk);
    send = 1'b0;
    check("pp_accept_level", level, 3'd4);
    check("pp_full_after", full, 1'b1);
    wait_idle("fifo", 0, 6000);
    compare_stream("fifo_order", 0);

    // Reset in the middle of a word.
    base = start_log.size();
    word = 32'hA5A5A5A5; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    n = 0;
    while (start_log.size() < base + 2 && n < 1000) begin @(negedge clk); n++; end
    check("rst_mid_second_start_timeout", start_log.size() >= base + 2, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_level", level, 3'd0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_full", full, 1'b0);
    reset = 1'b0;
    n = 0;
    while (!dut.tx_ready && n < 400) begin @(negedge clk); n++; end
    check("rst_mid_line_idle_timeout", dut.tx_ready, 1'b1);
    repeat (4) @(negedge clk);
    check("rst_mid_at_most_two", rx_q0.size() <= 2, 1'b1);
    foreach (rx_q0[i]) check("rst_mid_byte", rx_q0[i], 8'hA5);
    rx_q0.delete();
    word = 32'h000000FF; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    wait_idle("post_rst", 0, 2000);
    compare_stream("post_rst", 0);

    // Random burst: words and gaps random, drops decided by the model.
    for (int i = 0; i < 7; i++) begin
      word = $urandom; send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle("rand", 0, 8000);
    check("rand_level_end", level, 3'd0);
    compare_stream("rand", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/serial_word_tx.md
SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- baud_rate, 115_200, UART bit rate.
- comm_clk_frequency, 100_000_000, clk frequency in Hz.
- BYTES, 4, bytes per word (1..8).
- FIFO_DEPTH, 4, queued words (power of two, 2..16).
- MSB_FIRST, 1, 1 = byte [8*BYTES-1 -: 8] sent first; 0 = byte [7:0] sent first.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the only clock.
- reset, in, 1, asynchronous, active-high.
- word, in, 8*BYTES, data word.
- send, in, 1, write strobe; one word per cycle.
- full, out, 1, FIFO full.
- busy, out, 1, FIFO non-empty or serialiser active.
- level, out, $clog2(FIFO_DEPTH)+1, words queued.
- TxD, out, 1, serial line.

REQ-003 The block SHALL instantiate uart_transmitter with the same baud_rate and comm_clk_frequency, connected as follows:
- rx_new_byte = start pulse.
- rx_byte = out_byte.
- tx_ready = tx_ready.
- uart_tx = TxD.

Function
REQ-004 The block SHALL write word into the FIFO on any cycle with send=1 and full=0, and SHALL ignore send=1 when full=1 (word dropped, no state change).

REQ-005 The block SHALL accept a write to an empty FIFO in the same cycle the FSM is IDLE, with no bubble; the first start pulse occurs no earlier than 2 cycles after the write.

REQ-006 The serialiser FSM SHALL have states IDLE, LOAD, START, HOLD and, only when the macro is defined, CHK.

REQ-007 IDLE -> LOAD when the FIFO is non-empty. LOAD SHALL pop one word into shift register sr, clear byte counter cnt, and go to START.

REQ-008 START SHALL wait for tx_ready=1, then drive a single-cycle start pulse with out_byte = the next byte per MSB_FIRST, shift sr by 8, increment cnt, and go to HOLD.

REQ-009 HOLD SHALL keep start=0 for at least one cycle, then on tx_ready=1 go to:
- START if cnt<BYTES;
- CHK if cnt==BYTES and the macro is defined;
- else LOAD if the FIFO is non-empty, otherwise IDLE.

REQ-010 start SHALL never be high on two consecutive cycles, and never while tx_ready=0.

REQ-011 Simultaneous push and pop SHALL leave level unchanged; push while full and pop in the same cycle SHALL still be rejected (full is evaluated before the pop).

REQ-012 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full = (level==FIFO_DEPTH), empty = (level==0).

REQ-013 busy SHALL equal (level!=0) or (FSM!=IDLE).

REQ-014 Bytes on TxD SHALL appear in FIFO order, with no byte duplicated or skipped.

Reset
REQ-015 While reset=1, the block SHALL hold these values:
- FSM=IDLE.
- level=0; pointers=0.
- full=0, busy=0.
- start=0, out_byte=0, sr=0, cnt=0.
- checksum accumulator=0.

REQ-016 Reset asserted mid-word SHALL discard all remaining bytes and queued words. A byte already handed to uart_transmitter (which has no reset) completes on TxD. After reset deassertion, the first new start pulse SHALL occur only after tx_ready=1 is observed.

Configuration
REQ-017 With SERIAL_TX_CHECKSUM_EN defined, the block SHALL behave as follows:
- XOR each sent byte of a word into an 8-bit accumulator, cleared in LOAD.
- In CHK, wait for tx_ready, pulse start with out_byte = accumulator, then go to HOLD-equivalent timing before LOAD/IDLE.
- Each word therefore costs BYTES+1 bytes on the line.

REQ-018 Without SERIAL_TX_CHECKSUM_EN, the CHK state, the accumulator and the checksum byte SHALL NOT exist, and each word costs exactly BYTES bytes.

Verification (baud_rate=comm_clk_frequency/16 for sim speed)
REQ-019 Single word: BYTES=4, MSB_FIRST=1, push 32'hDEADBEEF once.
- Required: TxD decodes DE AD BE EF.
- Required: busy falls after the last stop bit.
- Required: exactly 4 start pulses.

REQ-020 Byte order: MSB_FIRST=0, push 32'h01020304.
- Required: TxD decodes 04 03 02 01.

REQ-021 FIFO full/drop: FIFO_DEPTH=4, push 6 words 0x11111111..0x66666666 on consecutive cycles.
- Required: full=1 after the 4th push (5th push lands while full); level=4.
- Required: 0x55555555 and 0x66666666 are never sent.
- Required: the first 4 words are sent in order.

REQ-022 Simultaneous push/pop: while full and the FSM pops, assert send.
- Required: the word is rejected.
- Required: the next-cycle push is accepted; level returns to FIFO_DEPTH.

REQ-023 Reset mid-word: assert reset for 3 cycles after the 2nd byte's start pulse of 32'hA5A5A5A5.
- Required: at most 2 bytes on TxD.
- Required: level=0, busy=0.
- Required: a subsequent push of 32'h0000_00FF sends 00 00 00 FF.

REQ-024 Checksum: with SERIAL_TX_CHECKSUM_EN defined, push 32'h12345678.
- Required: TxD decodes 12 34 56 78 08 (0x12^0x34^0x56^0x78=0x08).
- Required: without the macro, only 4 bytes are sent.
